// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer blocks (write side and read
// side both import this package).
//   FIFO_ADDR_WIDTH : default RAM address width
//   FIFO_DEPTH      : default FIFO depth (2**FIFO_ADDR_WIDTH)
//   bin2gray        : binary -> reflected Gray code, masked to 'w' bits
//   gray2bin        : reflected Gray code -> binary, masked to 'w' bits
// The conversion functions work on a 32-bit container so one pair of
// functions serves every pointer width. Callers zero-extend the operand and
// size-cast the result back to the pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

  // Mask selecting the low 'w' bits of the 32-bit container.
  function automatic logic [31:0] width_mask(input int w);
    logic [31:0] m;
    m = '1;
    if (w < 32) begin
      m = (32'd1 << w) - 32'd1;
    end
    return m;
  endfunction

  // Adjacent binary values map to Gray codes that differ in exactly one bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] bm;
    bm = b & width_mask(w);
    return (bm ^ (bm >> 1)) & width_mask(w);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. The
  // log-step prefix XOR computes that without a width-dependent loop bound.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = g & width_mask(w);
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b & width_mask(w);
  endfunction

endpackage

// File: rtl/fifo_sync_nff.sv
// ---------------------------------------------------------------------------
// fifo_sync_nff
// Multi-flop synchroniser for Gray-coded pointers crossing between the FIFO
// clock domains. Because the source is Gray coded, at most one bit is in
// flight at a time, so sampling a whole bus through parallel flop chains
// yields either the old or the new pointer, never a mixture.
// Ports:
//   clk : destination-domain clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input bus (WIDTH bits)
//   q   : output of the last stage (WIDTH bits)
// ---------------------------------------------------------------------------
module fifo_sync_nff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift chain: stage[0] samples the asynchronous input, each later stage
  // gives the previous one a full clock period to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
// Write-domain controller of the async FIFO. Owns the binary and Gray write
// pointers, synchronises the read-domain Gray pointer into w_clk and derives
// registered full / almost-full / fill-level flags plus a sticky overflow.
// It drives the write port of the dual-port RAM directly.
// Ports:
//   w_clk        : write clock (only clock in this block)
//   w_rst        : synchronous active-high reset
//   winc         : write request from the producer
//   rptr_gray    : read-domain Gray pointer (asynchronous to w_clk)
//   wovf_clr     : clears the sticky overflow flag
//   wclken       : RAM write enable (combinational)
//   waddr        : RAM write address, low ADDR_WIDTH bits of the pointer
//   wptr_gray    : registered Gray write pointer, to the read-side sync
//   wfull        : registered full flag
//   walmost_full : registered almost-full flag (free slots <= AF_TH)
//   wlevel       : registered fill level 0..depth
//   woverflow    : sticky, set when a write is attempted while full
// The pointers carry one extra MSB beyond the address so that a full FIFO
// (pointers one lap apart) is distinguishable from an empty one.
// ---------------------------------------------------------------------------
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int AF_TH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  wovf_clr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;

  // Occupancy at or above which the almost-full flag is raised.
  localparam logic [PW-1:0] AF_LIMIT = PW'((1 << ADDR_WIDTH) - AF_TH);

  // A full FIFO has the write pointer exactly one lap ahead of the read
  // pointer. In Gray code that means the top two bits inverted and the
  // remaining bits equal, so flipping those two bits of the synchronised
  // read pointer gives the "full" comparison value.
  localparam logic [PW-1:0] FULL_FLIP = PW'(3 << (ADDR_WIDTH - 1));

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wlevel_next;
  logic          accepted;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  // Bring the read pointer into the write domain. Only the final stage is
  // ever looked at; the intermediate stages may be metastable.
  fifo_sync_nff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (PW)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (w_rst),
    .d   (rptr_gray),
    .q   (rq_sync)
  );

  // Next-state logic for the pointers and flags. The full and level terms
  // compare against a read pointer that is SYNC_STAGES cycles stale, which
  // can only make the FIFO look fuller than it is -- never emptier -- so
  // the producer is never allowed to overwrite unread data.
  always_comb begin
    accepted          = winc & ~wfull;
    wbin_next         = wbin + PW'(accepted);
    wgray_next        = PW'(bin2gray(32'(wbin_next), PW));
    rbin_sync         = PW'(gray2bin(32'(rq_sync), PW));
    wlevel_next       = wbin_next - rbin_sync;
    wfull_next        = (wgray_next == (rq_sync ^ FULL_FLIP));
    walmost_full_next = (wlevel_next >= AF_LIMIT);
    woverflow_next    = (winc & wfull) | (woverflow & ~wovf_clr);
  end

  // Pointer and flag registers. Reset dominates all other inputs and also
  // clears the synchroniser, so the read domain must be reset alongside.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wlevel       <= wlevel_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      woverflow    <= woverflow_next;
    end
  end

  // The RAM write happens at the current address on the same edge that
  // advances the pointer. The enable is also held low during reset so no
  // stray word is written while the pointers are being cleared.
  assign wclken = winc & ~wfull & ~w_rst;
  assign waddr  = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_fifo_wptr_full
// Directed bench for the FIFO write-pointer controller (ADDR_WIDTH=4,
// AF_TH=2, SYNC_STAGES=2). A table of single-cycle vectors covers reset,
// fill, overflow and drain visibility; hand-written sequences cover the
// streaming wrap-around and a mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fifo_wptr_full;

  logic       w_clk;
  logic       w_rst;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       wovf_clr;
  logic       wclken;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(
    .ADDR_WIDTH  (4),
    .AF_TH       (2),
    .SYNC_STAGES (2)
  ) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wovf_clr     (wovf_clr),
    .wclken       (wclken),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic       rst;
    logic       winc;
    logic       clr;
    logic [4:0] rptr;
    logic       exp_wclken;
    logic [3:0] exp_waddr;
    logic [4:0] exp_gray;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] g(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input int rst, input int wi, input int clr,
                              input int rptr, input int wen, input int addr,
                              input int gray, input int level, input int full,
                              input int af, input int ovf);
    vec_t v;
    v.rst        = 1'(rst);
    v.winc       = 1'(wi);
    v.clr        = 1'(clr);
    v.rptr       = 5'(rptr);
    v.exp_wclken = 1'(wen);
    v.exp_waddr  = 4'(addr);
    v.exp_gray   = 5'(gray);
    v.exp_level  = 5'(level);
    v.exp_full   = 1'(full);
    v.exp_af     = 1'(af);
    v.exp_ovf    = 1'(ovf);
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one vector, check the combinational enable before the edge and
  // all registered outputs one time unit after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    w_rst     = v.rst;
    winc      = v.winc;
    wovf_clr  = v.clr;
    rptr_gray = v.rptr;
    #1;
    checkOutput({tag, ".wclken"}, 32'(wclken), 32'(v.exp_wclken));
    @(posedge w_clk);
    #1;
    checkOutput({tag, ".waddr"},        32'(waddr),        32'(v.exp_waddr));
    checkOutput({tag, ".wptr_gray"},    32'(wptr_gray),    32'(v.exp_gray));
    checkOutput({tag, ".wlevel"},       32'(wlevel),       32'(v.exp_level));
    checkOutput({tag, ".wfull"},        32'(wfull),        32'(v.exp_full));
    checkOutput({tag, ".walmost_full"}, 32'(walmost_full), 32'(v.exp_af));
    checkOutput({tag, ".woverflow"},    32'(woverflow),    32'(v.exp_ovf));
  endtask

  task automatic doReset();
    w_rst     = 1'b1;
    winc      = 1'b0;
    wovf_clr  = 1'b0;
    rptr_gray = '0;
    repeat (3) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
  endtask

  initial begin
    int wcount;
    int rnow;
    int sb1;
    int sb2;
    int used;
    int msb_toggles;
    int wraps;
    logic [4:0] prev_gray;
    logic [3:0] prev_waddr;

    w_rst     = 1'b1;
    winc      = 1'b1;
    wovf_clr  = 1'b0;
    rptr_gray = '0;

    // Reset with write requests pending.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Fill 16 words with the reader idle.
    for (int k = 1; k <= 16; k++) begin
      vecs.push_back(mk(0, 1, 0, 0, 1, k % 16, g(k), k,
                        (k == 16) ? 1 : 0, (k >= 14) ? 1 : 0, 0));
    end
    // 17th request: rejected, overflow set, pointers held.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'b11000, 16, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'b11000, 16, 1, 1, 1));
    // Clear alone, clear against set, hold, clear again.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11000, 16, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 5'b11000, 16, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'b11000, 16, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11000, 16, 1, 1, 0));
    // Reader advances to 4: full visible as cleared on the 3rd edge.
    vecs.push_back(mk(0, 0, 0, 5'b00110, 0, 0, 5'b11000, 16, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b00110, 0, 0, 5'b11000, 16, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b00110, 0, 0, 5'b11000, 12, 0, 0, 0));
    // Space is available again: next write accepted at address 0.
    vecs.push_back(mk(0, 1, 0, 5'b00110, 1, 1, 5'b11001, 13, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
    end

    // Streaming wrap-around: reader trails the writer by 3 words.
    doReset();
    wcount      = 0;
    rnow        = 0;
    sb1         = 0;
    sb2         = 0;
    msb_toggles = 0;
    wraps       = 0;
    prev_gray   = '0;
    prev_waddr  = '0;
    for (int i = 0; i < 40; i++) begin
      winc      = 1'b1;
      rptr_gray = g(rnow % 32);
      #1;
      checkOutput("wrap.wclken", 32'(wclken), 32'd1);
      @(posedge w_clk);
      used   = sb2;
      sb2    = sb1;
      sb1    = rnow;
      wcount = wcount + 1;
      #1;
      checkOutput("wrap.waddr",     32'(waddr),     32'(wcount % 16));
      checkOutput("wrap.wptr_gray", 32'(wptr_gray), 32'(g(wcount % 32)));
      checkOutput("wrap.wlevel",    32'(wlevel),    32'((wcount - used) & 31));
      checkOutput("wrap.wfull",     32'(wfull),     32'd0);
      checkOutput("wrap.gray_step",
                  32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
      if (wptr_gray[4] != prev_gray[4]) msb_toggles++;
      if (prev_waddr == 4'd15 && waddr == 4'd0) wraps++;
      prev_gray  = wptr_gray;
      prev_waddr = waddr;
      rnow = (wcount >= 3) ? wcount - 3 : 0;
    end
    checkOutput("wrap.msb_toggles", 32'(msb_toggles), 32'd2);
    checkOutput("wrap.addr_wraps",  32'(wraps),       32'd2);

    // Mid-operation reset with 9 words outstanding.
    doReset();
    winc = 1'b1;
    repeat (9) @(posedge w_clk);
    #1;
    winc = 1'b0;
    checkOutput("midrst.level_before", 32'(wlevel), 32'd9);
    w_rst = 1'b1;
    winc  = 1'b1;
    #1;
    checkOutput("midrst.wclken_in_reset", 32'(wclken), 32'd0);
    @(posedge w_clk);
    #1;
    checkOutput("midrst.waddr",     32'(waddr),        32'd0);
    checkOutput("midrst.wptr_gray", 32'(wptr_gray),    32'd0);
    checkOutput("midrst.wlevel",    32'(wlevel),       32'd0);
    checkOutput("midrst.wfull",     32'(wfull),        32'd0);
    checkOutput("midrst.af",        32'(walmost_full), 32'd0);
    checkOutput("midrst.ovf",       32'(woverflow),    32'd0);
    w_rst = 1'b0;
    #1;
    checkOutput("midrst.first_waddr",  32'(waddr),  32'd0);
    checkOutput("midrst.first_wclken", 32'(wclken), 32'd1);
    @(posedge w_clk);
    #1;
    winc = 1'b0;
    checkOutput("midrst.after_waddr", 32'(waddr),     32'd1);
    checkOutput("midrst.after_level", 32'(wlevel),    32'd1);
    checkOutput("midrst.after_gray",  32'(wptr_gray), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
